// File: rtl/tff_ctrl_pkg.sv
// Shared types and default sizing for the toggle-cell controller.
package tff_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : tff_ctrl_pkg

// File: rtl/tff_cell.sv
// Single toggle flip-flop: inverts its output on every rising edge with i_t high.
module tff_cell (
  input  logic clk,
  input  logic reset,
  input  logic i_t,
  output logic o_q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_q <= 1'b0;
    end else if (i_t) begin
      o_q <= ~o_q;
    end
  end

endmodule : tff_cell

// File: rtl/tff_toggle_ctrl.sv
// Command-driven controller that toggles a masked set of TFF cells for N cycles,
// with abort, a one-cycle done pulse and a ready/valid command handshake.
module tff_toggle_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_mask,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_abort,
  output logic [WIDTH-1:0] o_q,
  output logic             o_busy,
  output logic             o_done
);

  state_e           state_q;
  logic [CNT_W-1:0] rem_q;
  logic [WIDTH-1:0] mask_q;
  logic             tog_en_c;
  logic [WIDTH-1:0] t_c;

  // Control state: command latch, remaining count and phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      mask_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            mask_q  <= i_mask;
            rem_q   <= i_count;
            state_q <= (i_count == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // Abort takes priority over the final-count transition.
          if (i_abort) begin
            state_q <= DONE;
          end else begin
            rem_q <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_busy   = (state_q != IDLE);
  assign o_done   = (state_q == DONE);
  assign tog_en_c = (state_q == RUN) && !i_abort;
  assign t_c      = mask_q & {WIDTH{tog_en_c}};

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    tff_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .i_t   (t_c[i]),
      .o_q   (o_q[i])
    );
  end

endmodule : tff_toggle_ctrl

// File: doc/tff_toggle_ctrl.md
TFF_TOGGLE_CTRL -- requirements
Module: tff_toggle_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, number of toggle cells controlled.
REQ-002 Parameter CNT_W, default 8, width of the toggle-count field.
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 i_valid  input  1  command valid.
REQ-006 o_ready  output  1  command accepted when i_valid && o_ready at a rising edge.
REQ-007 i_mask  input  WIDTH  per-cell toggle enable for the command.
REQ-008 i_count  input  CNT_W  number of toggle cycles to apply, 0 to 2^CNT_W-1.
REQ-009 i_abort  input  1  terminate the running command.
REQ-010 o_q  output  WIDTH  current toggle-cell outputs.
REQ-011 o_busy  output  1  high whenever state is not IDLE.
REQ-012 o_done  output  1  one-cycle completion pulse.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE; o_ready = (state == IDLE), combinational from state only.
REQ-014 Accept in IDLE: latch i_mask and i_count; i_count==0 -> DONE, else -> RUN; o_q unchanged on the accept edge.
REQ-015 Accept at edge k with count N>0: cells with mask bit 1 toggle on edges k+1..k+N; mask-0 cells hold.
REQ-016 Remaining-count register loads N on accept, decrements once per RUN edge; on the edge where it reaches 0, state -> DONE.
REQ-017 DONE lasts exactly one cycle with o_done=1, then -> IDLE; o_done is 0 in every other state.
REQ-018 i_abort sampled high in RUN: no toggle on that edge, state -> DONE; i_abort ignored in IDLE and DONE.
REQ-019 i_abort and final-count edge coincident: abort wins, so the last toggle is suppressed.
REQ-020 i_valid in RUN or DONE is ignored, no latching; the command is accepted on the first IDLE-cycle edge while still valid.
REQ-021 o_q SHALL persist across commands; only reset clears it.
REQ-022 i_mask == 0 with N>0 SHALL still run N cycles and pulse o_done, o_q unchanged.
REQ-023 Counter arithmetic is unsigned CNT_W bits; no wrap, since decrement stops at 0.

Reset
REQ-024 reset low SHALL immediately force state=IDLE, o_q=0, remaining count=0, latched mask=0, o_done=0, o_busy=0, o_ready=1.
REQ-025 Reset mid-RUN SHALL abandon the command with no o_done pulse.
REQ-026 First accept possible on the first rising edge after reset deasserts.

Structure
REQ-027 Package tff_ctrl_pkg SHALL hold the state typedef (IDLE, RUN, DONE) and the default WIDTH/CNT_W constants.
REQ-028 Each bit SHALL be one instance of sub-module tff_cell (clk, reset async active-low, i_t, o_q) with i_t = mask[i] && toggle-enable.
REQ-029 Toggle-enable = (state==RUN) && !i_abort; no other logic drives the cells.

Verification
REQ-030 o_q=0, mask=4'b0101, count=3 -> o_q 0101, 0000, 0101 on the next three edges; o_done high the following cycle; o_ready high the cycle after.
REQ-031 count=0, mask=4'b1111 -> no toggle, o_done one cycle after accept, o_q unchanged.
REQ-032 mask=4'b1111, count=10, i_abort after 2 toggles -> o_q=0000 held, o_done next cycle, no further toggles.
REQ-033 i_valid held through RUN with a second command -> second command latched only on the first IDLE edge; the first command is unaffected.
REQ-034 mask=4'b0001, count=255 -> o_q ends 0001, o_done 256 cycles after accept.
REQ-035 reset pulsed low mid-RUN (count=20) -> o_q=0, o_busy=0, o_ready=1 with no clock edge, and no o_done.
